// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state, digit and segment-glyph definitions for countdown_timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  // Segment order {g,f,e,d,c,b,a}, 1 = segment lit
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] glyph(input bcd_t d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic bcd_t clamp_digit(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - one BCD digit to 7-segment decoder with blanking and selectable polarity
module bcd_to_7seg
  import timer_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] lit;

  always_comb begin
    lit = blank ? SEG_BLANK : glyph(digit);
    seg = SEG_ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - two-digit BCD countdown timer stepped by edges of the divided clock
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       itick,
  input  logic       iload,
  input  logic [7:0] iload_val,
  input  logic       istart,
  input  logic       ipause,
  output logic [7:0] obcd,
  output logic [6:0] ohex1,
  output logic [6:0] ohex0,
  output logic       odone,
  output logic       orunning
);

  localparam logic [7:0] PRESCALE_LAST = 8'(TICKS_PER_STEP - 1);

  state_t     state;
  bcd_t       tens;
  bcd_t       ones;
  bcd_t       last_tens;
  bcd_t       last_ones;
  logic       tick_q;
  logic [7:0] prescale;
  logic       blink;

  logic tick_edge;
  logic step;
  logic blank;

  // itick is already synchronous to iclk, so one flop suffices for edge detection
  assign tick_edge = itick & ~tick_q;
  assign step      = tick_edge && (prescale == PRESCALE_LAST);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state     <= IDLE;
      tens      <= 4'd0;
      ones      <= 4'd0;
      last_tens <= 4'd0;
      last_ones <= 4'd0;
      tick_q    <= 1'b0;
      prescale  <= 8'd0;
      blink     <= 1'b1;
    end else begin
      tick_q <= itick;
      if (iload) begin
        state     <= IDLE;
        tens      <= clamp_digit(iload_val[7:4]);
        ones      <= clamp_digit(iload_val[3:0]);
        last_tens <= clamp_digit(iload_val[7:4]);
        last_ones <= clamp_digit(iload_val[3:0]);
        prescale  <= 8'd0;
        blink     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (istart && ({tens, ones} != 8'h00)) state <= RUN;
          end
          RUN: begin
            // A pause request swallows any coincident tick without advancing the prescaler
            if (ipause) begin
              state <= PAUSE;
            end else if (tick_edge) begin
              if (step) begin
                prescale <= 8'd0;
                if (ones == 4'd0) begin
                  ones <= 4'd9;
                  tens <= tens - 4'd1;
                end else begin
                  ones <= ones - 4'd1;
                end
                if ({tens, ones} == 8'h01) state <= DONE;
              end else begin
                prescale <= prescale + 8'd1;
              end
            end
          end
          PAUSE: begin
            if (istart) state <= RUN;
          end
          DONE: begin
            // blink is re-armed on exit so the next DONE entry starts with digits shown
            if (istart) begin
              state <= IDLE;
              tens  <= last_tens;
              ones  <= last_ones;
              blink <= 1'b1;
            end else if (tick_edge) begin
              blink <= ~blink;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign obcd     = {tens, ones};
  assign odone    = (state == DONE);
  assign orunning = (state == RUN);
  assign blank    = (state == DONE) && !blink;

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex1 (
    .digit (tens),
    .blank (blank),
    .seg   (ohex1)
  );

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex0 (
    .digit (ones),
    .blank (blank),
    .seg   (ohex0)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed bench for countdown_timer with a decimal reference model
module tb_countdown_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       iclk = 1'b0;
  logic       irst_n = 1'b0;
  logic       itick = 1'b0;
  logic       iload = 1'b0;
  logic [7:0] iload_val = 8'h00;
  logic       istart = 1'b0;
  logic       ipause = 1'b0;

  logic [7:0] obcd_a, obcd_b;
  logic [6:0] ohex1_a, ohex1_b, ohex0_a, ohex0_b;
  logic       odone_a, odone_b, orunning_a, orunning_b;

  always #5 iclk = ~iclk;

  countdown_timer #(.TICKS_PER_STEP(1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .iclk(iclk), .irst_n(irst_n), .itick(itick), .iload(iload), .iload_val(iload_val),
    .istart(istart), .ipause(ipause), .obcd(obcd_a), .ohex1(ohex1_a), .ohex0(ohex0_a),
    .odone(odone_a), .orunning(orunning_a)
  );

  countdown_timer #(.TICKS_PER_STEP(3), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .iclk(iclk), .irst_n(irst_n), .itick(itick), .iload(iload), .iload_val(iload_val),
    .istart(istart), .ipause(ipause), .obcd(obcd_b), .ohex1(ohex1_b), .ohex0(ohex0_b),
    .odone(odone_b), .orunning(orunning_b)
  );

  logic [23:0] act [2];
  assign act[0] = {obcd_a, ohex1_a, ohex0_a, odone_a, orunning_a};
  assign act[1] = {obcd_b, ohex1_b, ohex0_b, odone_b, orunning_b};

  int checks = 0;
  int errors = 0;

  // Reference model: count kept as a plain decimal number, steps counted as edges seen while running
  int       per [2] = '{1, 3};
  int       m_state [2];
  int       m_count [2];
  int       m_last  [2];
  int       m_edges [2];
  bit       m_blink [2];
  bit       m_prev;
  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int min9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = M_IDLE;
      m_count[i] = 0;
      m_last[i]  = 0;
      m_edges[i] = 0;
      m_blink[i] = 1'b1;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_update();
    bit edge_seen;
    edge_seen = itick && !m_prev;
    m_prev = itick;
    for (int i = 0; i < 2; i++) begin
      if (iload) begin
        m_state[i] = M_IDLE;
        m_count[i] = 10 * min9(iload_val[7:4]) + min9(iload_val[3:0]);
        m_last[i]  = m_count[i];
        m_edges[i] = 0;
        m_blink[i] = 1'b1;
      end else if (m_state[i] == M_IDLE) begin
        if (istart && m_count[i] != 0) m_state[i] = M_RUN;
      end else if (m_state[i] == M_RUN) begin
        if (ipause) m_state[i] = M_PAUSE;
        else if (edge_seen) begin
          m_edges[i]++;
          if (m_edges[i] == per[i]) begin
            m_edges[i] = 0;
            m_count[i]--;
            if (m_count[i] == 0) m_state[i] = M_DONE;
          end
        end
      end else if (m_state[i] == M_PAUSE) begin
        if (istart) m_state[i] = M_RUN;
      end else begin
        if (istart) begin
          m_state[i] = M_IDLE;
          m_count[i] = m_last[i];
          m_blink[i] = 1'b1;
        end else if (edge_seen) m_blink[i] = !m_blink[i];
      end
    end
  endtask

  function automatic logic [23:0] expect_vec(input int i);
    logic [7:0] bcd;
    logic [6:0] h1, h0;
    bit         blank;
    bcd   = 8'((m_count[i] / 10) * 16 + (m_count[i] % 10));
    blank = (m_state[i] == M_DONE) && !m_blink[i];
    h1    = blank ? 7'h00 : glyph_tab[m_count[i] / 10];
    h0    = blank ? 7'h00 : glyph_tab[m_count[i] % 10];
    return {bcd, ~h1, ~h0, (m_state[i] == M_DONE), (m_state[i] == M_RUN)};
  endfunction

  task automatic cyc();
    @(posedge iclk);
    model_update();
    @(negedge iclk);
  endtask

  task automatic pulse_tick();
    itick = 1'b1;
    cyc();
    itick = 1'b0;
    cyc();
  endtask

  task automatic load(input logic [7:0] v);
    iload_val = v;
    iload = 1'b1;
    cyc();
    iload = 1'b0;
  endtask

  task automatic start();
    istart = 1'b1;
    cyc();
    istart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iclk);
    {itick, iload, istart, ipause} = 4'b0;
    iload_val = 8'h00;
    irst_n = 1'b0;
    model_reset();
    @(negedge iclk);
    @(negedge iclk);
    irst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act[i] !== {8'h00, 7'b1000000, 7'b1000000, 2'b00}) begin
        errors++;
        $display("FAIL reset dut%0d: got %h want %h", i, act[i], {8'h00, 7'b1000000, 7'b1000000, 2'b00});
      end
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act[i] !== expect_vec(i)) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got %h want %h", i, act[i], expect_vec(i));
      end
    end
  endtask

  task automatic test_countdown();
    logic [7:0] want;
    do_reset();
    load(8'h12);
    start();
    checks++;
    if (orunning_a !== 1'b1 || obcd_a !== 8'h12) begin
      errors++;
      $display("FAIL cd_start: got run=%b bcd=%h want run=1 bcd=12", orunning_a, obcd_a);
    end
    for (int e = 1; e <= 12; e++) begin
      itick = 1'b1;
      cyc();
      want = 8'(((12 - e) / 10) * 16 + (12 - e) % 10);
      checks++;
      if (obcd_a !== want || odone_a !== (e == 12) || orunning_a !== (e != 12)) begin
        errors++;
        $display("FAIL cd_edge%0d: got bcd=%h done=%b run=%b want bcd=%h done=%b run=%b",
                 e, obcd_a, odone_a, orunning_a, want, (e == 12), (e != 12));
      end
      checks++;
      if (act[1] !== expect_vec(1)) begin
        errors++;
        $display("FAIL cd_model_b edge%0d: got %h want %h", e, act[1], expect_vec(1));
      end
      itick = 1'b0;
      cyc();
    end
  endtask

  task automatic test_pause();
    do_reset();
    load(8'h05);
    start();
    pulse_tick();
    pulse_tick();
    ipause = 1'b1;
    cyc();
    ipause = 1'b0;
    for (int e = 0; e < 3; e++) begin
      pulse_tick();
      checks++;
      if (obcd_a !== 8'h03 || orunning_a !== 1'b0 || odone_a !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold%0d: got bcd=%h run=%b want bcd=03 run=0", e, obcd_a, orunning_a);
      end
    end
    start();
    for (int e = 0; e < 3; e++) pulse_tick();
    checks++;
    if (obcd_a !== 8'h00 || odone_a !== 1'b1) begin
      errors++;
      $display("FAIL pause_done: got bcd=%h done=%b want bcd=00 done=1", obcd_a, odone_a);
    end
    checks++;
    if (act[1] !== expect_vec(1)) begin
      errors++;
      $display("FAIL pause_model_b: got %h want %h", act[1], expect_vec(1));
    end
  endtask

  task automatic test_clamp();
    do_reset();
    load(8'hAF);
    checks++;
    if (obcd_a !== 8'h99 || obcd_b !== 8'h99 || ohex1_a !== 7'b0010000) begin
      errors++;
      $display("FAIL clamp: got %h/%h hex1=%b want 99/99 hex1=0010000", obcd_a, obcd_b, ohex1_a);
    end
    load(8'h00);
    start();
    checks++;
    if (orunning_a !== 1'b0 || orunning_b !== 1'b0 || obcd_a !== 8'h00) begin
      errors++;
      $display("FAIL zero_start: got run=%b%b bcd=%h want run=00 bcd=00", orunning_a, orunning_b, obcd_a);
    end
  endtask

  task automatic test_done_blink();
    logic [6:0] want;
    do_reset();
    load(8'h02);
    start();
    pulse_tick();
    pulse_tick();
    for (int e = 1; e <= 4; e++) begin
      pulse_tick();
      want = (e % 2 == 1) ? 7'h7F : 7'h40;
      checks++;
      if (ohex1_a !== want || ohex0_a !== want || odone_a !== 1'b1) begin
        errors++;
        $display("FAIL blink%0d: got %b %b done=%b want %b", e, ohex1_a, ohex0_a, odone_a, want);
      end
    end
    start();
    checks++;
    if (obcd_a !== 8'h02 || odone_a !== 1'b0 || orunning_a !== 1'b0 || ohex0_a !== 7'b0100100) begin
      errors++;
      $display("FAIL done_restart: got bcd=%h done=%b hex0=%b want bcd=02 done=0 hex0=0100100",
               obcd_a, odone_a, ohex0_a);
    end
  endtask

  task automatic test_prescale();
    logic [7:0] want;
    do_reset();
    load(8'h02);
    start();
    for (int e = 1; e <= 6; e++) begin
      pulse_tick();
      want = 8'(2 - e / 3);
      checks++;
      if (obcd_b !== want || odone_b !== (e == 6)) begin
        errors++;
        $display("FAIL presc_edge%0d: got bcd=%h done=%b want bcd=%h done=%b", e, obcd_b, odone_b, want, (e == 6));
      end
    end
    load(8'h09);
    start();
    pulse_tick();
    pulse_tick();
    #2 irst_n = 1'b0;
    #1;
    checks++;
    if (obcd_a !== 8'h00 || obcd_b !== 8'h00 || orunning_a !== 1'b0 || orunning_b !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h run=%b%b want 00/00 run=00", obcd_a, obcd_b, orunning_a, orunning_b);
    end
    model_reset();
    @(negedge iclk);
    irst_n = 1'b1;
    start();
    checks++;
    if (orunning_b !== 1'b0 || obcd_b !== 8'h00) begin
      errors++;
      $display("FAIL last_load_lost: got run=%b bcd=%h want run=0 bcd=00", orunning_b, obcd_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      iload = ($urandom_range(0, 99) < 3);
      iload_val = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      istart = (m_state[0] != M_RUN && m_state[1] != M_RUN) && ($urandom_range(0, 7) == 0);
      ipause = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) == 0) itick = ~itick;
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act[i] !== expect_vec(i)) begin
          errors++;
          $display("FAIL random cyc%0d dut%0d: got %h want %h", n, i, act[i], expect_vec(i));
        end
      end
    end
    {iload, istart, ipause} = 3'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_pause();
    test_clamp();
    test_done_blink();
    test_prescale();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Two-digit BCD countdown timer consuming the slow square wave from the project clock divider.
- Runs in the fast system clock domain and edge-detects the divided clock rather than being clocked by it.
- Drives two 7-segment displays plus done/running status.
- Sits directly downstream of the divider; feeds board HEX displays and LEDs.

Parameters:
TICKS_PER_STEP, 1, number of divided-clock rising edges per one-count decrement (1..255)
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (board default), 0 = active-high

Ports:
iclk  input  1  system clock (50 MHz on hardware)
irst_n  input  1  asynchronous active-low reset
itick  input  1  divided clock level from the clock divider, synchronous to iclk
iload  input  1  load iload_val; level-sampled every cycle
iload_val  input  8  BCD preset, [7:4] tens, [3:0] ones
istart  input  1  start/resume (1-cycle pulse expected; level treated per cycle)
ipause  input  1  pause request
obcd  output  8  current count, BCD
ohex1  output  7  tens digit segments {g,f,e,d,c,b,a}
ohex0  output  7  ones digit segments
odone  output  1  high in DONE state
orunning  output  1  high in RUN state

Behaviour:
- Clock and reset: one clock iclk; reset irst_n is asynchronous, active-low. All flops clear on irst_n low.
- Reset values:
  - state IDLE; count 00; last_load 00; itick_q 0; prescale 0; blink 1.
  - obcd=00, odone=0, orunning=0, ohex1/ohex0 show glyph "0".
- Tick detect: itick_q registers itick; tick_edge = itick & ~itick_q. If itick is high on the first cycle after reset, that counts as an edge.
- Prescaler: counts tick_edge only in RUN. step fires on the tick_edge at which prescale == TICKS_PER_STEP-1; prescale then returns to 0.
- States:
  - IDLE:
    - istart with count != 00 -> RUN.
    - istart with count == 00 -> stays IDLE.
  - RUN:
    - step: BCD decrement. Ones 0 -> 9 with tens-1; otherwise ones-1.
    - If the pre-decrement value is 01 -> count 00 and state DONE in the same cycle.
    - ipause -> PAUSE.
  - PAUSE:
    - istart -> RUN.
    - ipause ignored.
    - tick edges ignored; prescale holds.
  - DONE:
    - blink toggles on every tick_edge.
    - istart -> IDLE with count = last_load.
- iload, any state:
  - Next state IDLE.
  - count = last_load = iload_val, with each digit > 9 clamped to 9.
  - prescale cleared; blink set 1.
- Priority within one cycle: iload > istart > ipause > step. A step coinciding with ipause, or with istart from IDLE, does not decrement.
- Latency: a tick_edge detected in cycle N changes obcd in cycle N+1 (registered count; obcd = count).
- Displays:
  - Decoded combinationally from the registered count.
  - In DONE with blink=0, both displays are blank (all segments off, respecting polarity).
  - Segment polarity is set by SEG_ACTIVE_LOW.
- Status outputs: odone = (state==DONE); orunning = (state==RUN). Both are registered-state decodes with no extra latency.
- Reset mid-RUN: returns to IDLE/00 asynchronously. last_load is lost (cleared to 00).

Decomposition:
- Package timer_pkg:
  - state_t enum {IDLE, RUN, PAUSE, DONE}
  - BCD digit typedef (logic [3:0])
  - 7-bit segment glyph constants for 0-9 and BLANK, active-high form
- Sub-module bcd_to_7seg:
  - 4-bit digit in, blank in, 7-bit segments out
  - parameter SEG_ACTIVE_LOW
  - instantiated twice

Test Plan:
1. Reset release with no inputs -> obcd=00, odone=0, orunning=0, ohex0=ohex1=7'b1000000 (active-low "0").
2. iload_val=8'h12, iload pulse, istart pulse, 12 itick rising edges (TICKS_PER_STEP=1) -> obcd steps 11,10,09,...,01,00. odone rises on the cycle after the 12th edge; orunning falls at the same time.
3. Load 8'h05, start, 2 edges, ipause, 3 edges, istart, 3 edges -> obcd 03 held through pause, then 00 and DONE.
4. Load 8'hAF -> obcd=99 (clamp). Load 8'h00 then istart -> stays IDLE, orunning=0.
5. In DONE, 4 tick edges -> displays alternate blank/"00" each edge. istart -> IDLE, obcd = last loaded value.
6. TICKS_PER_STEP=3: load 02, start, 6 edges -> decrements at edges 3 and 6 only. irst_n asserted mid-RUN -> immediate obcd=00, IDLE.
